// File: rtl/block_ram_sync.sv
// Single-port synchronous RAM, read-first, registered read data.
// Optional BLOCK_RAM_OUTREG_EN adds a second output register (2-cycle read latency).
module block_ram_sync #(
  parameter  int unsigned DATA = 32,
  parameter  int unsigned SIZE = 65_536,
  localparam int unsigned AW   = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            write_enable,
  input  logic [DATA-1:0] data,
  input  logic [AW-1:0]   addr,
  output logic [DATA-1:0] data_out
);

  logic [DATA-1:0] mem_q [SIZE];
  logic            in_range_c;
  logic [DATA-1:0] rd_d;
  logic [DATA-1:0] rd_q;

  // Only reachable when SIZE is not a power of two.
  assign in_range_c = (32'(addr) < SIZE);

  // Array write: no reset on the contents, writes blocked while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && write_enable && in_range_c) begin
      mem_q[addr] <= data;
    end
  end

  always_comb begin
    rd_d = '0;
    if (in_range_c) begin
      rd_d = mem_q[addr];
    end
  end

  // Read register samples the pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

`ifdef BLOCK_RAM_OUTREG_EN
  logic [DATA-1:0] out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= rd_q;
    end
  end

  assign data_out = out_q;
`else
  assign data_out = rd_q;
`endif

endmodule

// File: tb/tb_block_ram_sync.sv
// Directed bench for block_ram_sync: abstract memory model checked every cycle
// plus literal expectations from hand-computed scenarios.
module tb_block_ram_sync;

  localparam int unsigned DATA = 32;
  localparam int unsigned SIZE = 65_536;
  localparam int unsigned AW   = 16;
`ifdef BLOCK_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            write_enable = 1'b0;
  logic [DATA-1:0] data = '0;
  logic [AW-1:0]   addr = '0;
  logic [DATA-1:0] data_out;

  int checks = 0;
  int errors = 0;
  int n_steps = 0;
  logic [DATA-1:0] hist [0:255];

  block_ram_sync #(.DATA(DATA), .SIZE(SIZE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .data         (data),
    .addr         (addr),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA-1:0] got, input logic [DATA-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, record data_out just after the rising edge.
  task automatic step(input logic r, input logic we, input logic [AW-1:0] a, input logic [DATA-1:0] d);
    @(negedge clk);
    rst_n = r;
    write_enable = we;
    addr = a;
    data = d;
    @(posedge clk);
    #2;
    n_steps++;
    hist[n_steps] = data_out;
  endtask

  // Extra cycles so a read issued on the last step reaches data_out.
  task automatic pad();
    for (int i = 1; i < LAT; i++) step(1'b1, 1'b0, addr, '0);
  endtask

  // Reference model: word-addressed store with unknown-until-written words,
  // and a LAT-deep queue of expected outputs.
  logic [DATA-1:0] mdl [int unsigned];
  logic            pv [LAT];
  logic [DATA-1:0] pd [LAT];

  initial begin
    for (int s = 0; s < LAT; s++) begin
      pv[s] = 1'b0;
      pd[s] = '0;
    end
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int s = 0; s < LAT; s++) begin
          pv[s] = 1'b1;
          pd[s] = '0;
        end
      end else begin
        for (int s = LAT - 1; s > 0; s--) begin
          pv[s] = pv[s-1];
          pd[s] = pd[s-1];
        end
        pv[0] = mdl.exists(32'(addr));
        pd[0] = pv[0] ? mdl[32'(addr)] : '0;
        if (write_enable) mdl[32'(addr)] = data;
      end
      #1;
      if (pv[LAT-1]) chk("model", data_out, pd[LAT-1]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, k1, k2;

    // Power-up reset, then give addr 5 a known value of 0.
    step(1'b0, 1'b0, 16'd0, '0);
    step(1'b0, 1'b0, 16'd0, '0);
    chk("reset_out", hist[n_steps], 32'h0);
    step(1'b1, 1'b1, 16'd5, 32'h0);

    // Writes presented during reset are dropped.
    step(1'b0, 1'b1, 16'd5, 32'hDEAD);
    step(1'b0, 1'b1, 16'd5, 32'hDEAD);
    chk("reset_hold_out", hist[n_steps], 32'h0);
    step(1'b1, 1'b0, 16'd5, '0);
    k0 = n_steps;
    pad();
    chk("reset_write_suppressed", hist[k0 + LAT - 1], 32'h0);

    // Basic write then read.
    step(1'b1, 1'b1, 16'h0010, 32'hCAFEBABE);
    step(1'b1, 1'b0, 16'h0010, '0);
    k0 = n_steps;
    pad();
    chk("write_read", hist[k0 + LAT - 1], 32'hCAFEBABE);

    // Read-during-write returns old contents.
    step(1'b1, 1'b1, 16'd7, 32'h11111111);
    step(1'b1, 1'b1, 16'd7, 32'h22222222);
    k0 = n_steps;
    step(1'b1, 1'b0, 16'd7, '0);
    k1 = n_steps;
    pad();
    chk("rdw_old", hist[k0 + LAT - 1], 32'h11111111);
    chk("rdw_new", hist[k1 + LAT - 1], 32'h22222222);

    // Address extremes.
    step(1'b1, 1'b1, 16'h0000, 32'h00000001);
    step(1'b1, 1'b1, 16'hFFFF, 32'hFFFFFFFF);
    step(1'b1, 1'b0, 16'h0000, '0);
    k0 = n_steps;
    step(1'b1, 1'b0, 16'hFFFF, '0);
    k1 = n_steps;
    pad();
    chk("addr_lo", hist[k0 + LAT - 1], 32'h00000001);
    chk("addr_hi", hist[k1 + LAT - 1], 32'hFFFFFFFF);

    // Stack-style push then pop on consecutive cycles.
    step(1'b1, 1'b1, 16'd0, 32'd10);
    step(1'b1, 1'b1, 16'd1, 32'd20);
    step(1'b1, 1'b1, 16'd2, 32'd30);
    step(1'b1, 1'b0, 16'd2, '0);
    k0 = n_steps;
    step(1'b1, 1'b0, 16'd1, '0);
    k1 = n_steps;
    step(1'b1, 1'b0, 16'd0, '0);
    k2 = n_steps;
    pad();
    chk("pop2", hist[k0 + LAT - 1], 32'd30);
    chk("pop1", hist[k1 + LAT - 1], 32'd20);
    chk("pop0", hist[k2 + LAT - 1], 32'd10);

    // Contents survive a reset pulse.
    step(1'b1, 1'b1, 16'd3, 32'hA5A5A5A5);
    step(1'b0, 1'b0, 16'd3, '0);
    chk("pulse_reset_out", hist[n_steps], 32'h0);
    step(1'b1, 1'b0, 16'd3, '0);
    k0 = n_steps;
    pad();
    chk("persist", hist[k0 + LAT - 1], 32'hA5A5A5A5);

    // Output holds with a steady address; a few mixed cycles for the model.
    step(1'b1, 1'b0, 16'h0010, '0);
    step(1'b1, 1'b0, 16'h0010, '0);
    k0 = n_steps;
    pad();
    chk("hold", hist[k0 + LAT - 1], 32'hCAFEBABE);
    step(1'b1, 1'b1, 16'h1234, 32'h0BADF00D);
    step(1'b1, 1'b0, 16'd7, '0);
    step(1'b1, 1'b0, 16'h1234, '0);
    k0 = n_steps;
    pad();
    chk("mixed", hist[k0 + LAT - 1], 32'h0BADF00D);
    step(1'b1, 1'b0, 16'd0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
